// File: rtl/aes_key_expander_if.sv
// aes_key_expander_if
//   Key-ingress and round-key request bundle for aes_key_expander.
//   The master drives key loads and round-key requests; the slave (the
//   expander) returns status, round keys and error pulses.
//
//   Handshake: key_load_in and round_key_req_in are single-cycle strobes
//   sampled on the rising clock edge; there is no backpressure. A request
//   sampled while ready_out=1 is answered one cycle later by exactly one
//   pulse, either round_key_valid_out (with round_key_out) or range_err_out.
//   A request sampled while ready_out=0, or together with a load, gets no
//   response.
//
// Signals:
//   key_load_in          load strobe, captures cipher_key_in
//   cipher_key_in        NK*32-bit cipher key, word 0 in the MSBs
//   busy_out             expansion in progress
//   ready_out            schedule complete, requests serviced
//   round_key_req_in     round-key request strobe
//   round_number_in      requested round 0..NR
//   decrypt_in           reverse round order for the request
//   round_key_out        NB*32-bit round key, word 0 in the MSBs
//   round_key_valid_out  one-cycle pulse, round_key_out valid
//   range_err_out        one-cycle pulse, round_number_in > NR
interface aes_key_expander_if #(
  parameter int NK__KEY_LENGTH           = 8,
  parameter int NB__BLOCK_LENGTH_IN_TEXT = 4
);
  logic                                     key_load_in;
  logic [NK__KEY_LENGTH*32-1:0]             cipher_key_in;
  logic                                     busy_out;
  logic                                     ready_out;
  logic                                     round_key_req_in;
  logic [NB__BLOCK_LENGTH_IN_TEXT-1:0]      round_number_in;
  logic                                     decrypt_in;
  logic [NB__BLOCK_LENGTH_IN_TEXT*32-1:0]   round_key_out;
  logic                                     round_key_valid_out;
  logic                                     range_err_out;

  modport master (
    output key_load_in, cipher_key_in, round_key_req_in, round_number_in, decrypt_in,
    input  busy_out, ready_out, round_key_out, round_key_valid_out, range_err_out
  );

  modport slave (
    input  key_load_in, cipher_key_in, round_key_req_in, round_number_in, decrypt_in,
    output busy_out, ready_out, round_key_out, round_key_valid_out, range_err_out
  );
endinterface

// File: rtl/aes_key_expander.sv
// aes_key_expander
//   Iterative AES key schedule. A load captures the cipher key into
//   w[0..NK-1]; the next TW-NK cycles compute one schedule word per cycle.
//   Once complete, 128-bit round keys are served on request in forward or
//   reverse (decrypt) order with a one-cycle latency.
//
// Ports:
//   clk_in      clock, rising edge
//   rst_in      asynchronous active-high reset
//   zeroize_in  synchronous wipe of store and round key (only with
//               AES_KEYEXP_ZEROIZE_EN defined)
//   bus         aes_key_expander_if.slave (load, request, status, key out)
//   fsm_state   debug view of the controller state
//
// Configuration macro: AES_KEYEXP_ZEROIZE_EN adds zeroize_in.

// One AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 = a^2 * a^4 * ... * a^128, which is the inverse (and maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] p;
    sq = x;
    p  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      p  = gf_mul(p, sq);
    end
    return p;
  endfunction

  logic [7:0] inv;
  assign inv = gf_inv(a);
  assign s   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_key_expander #(
  parameter int NK__KEY_LENGTH           = 8,
  parameter int NR__ROUNDS               = 14,
  parameter int NB__BLOCK_LENGTH_IN_TEXT = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
`ifdef AES_KEYEXP_ZEROIZE_EN
  input  logic                  zeroize_in,
`endif
  aes_key_expander_if.slave     bus,
  output logic [1:0]            fsm_state
);
  localparam int NK = NK__KEY_LENGTH;
  localparam int NR = NR__ROUNDS;
  localparam int NB = NB__BLOCK_LENGTH_IN_TEXT;
  localparam int TW = NB * (NR + 1);
  localparam int IW = $clog2(TW);

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, READY = 2'd2} state_t;

  state_t             state;
  logic [IW-1:0]      idx;      // index of the word being written
  logic [2:0]         pos;      // idx mod NK, kept incrementally
  logic [7:0]         rcon;
  logic [31:0]        w [TW];
  logic               busy_r;
  logic               ready_r;
  logic               valid_r;
  logic               err_r;
  logic [NB*32-1:0]   rk_r;

  logic [31:0]        w_prev;
  logic [31:0]        w_back;
  logic [31:0]        sb_in;
  logic [31:0]        sb_out;
  logic [31:0]        t;
  logic [31:0]        w_new;
  logic [NB-1:0]      eff_round;
  logic [IW-1:0]      kb;

  assign fsm_state              = state;
  assign bus.busy_out           = busy_r;
  assign bus.ready_out          = ready_r;
  assign bus.round_key_valid_out = valid_r;
  assign bus.range_err_out      = err_r;
  assign bus.round_key_out      = rk_r;

  // Next schedule word.
  assign w_prev = w[idx - IW'(1)];
  assign w_back = w[idx - IW'(NK)];
  assign sb_in  = (pos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a(sb_in[8*g +: 8]), .s(sb_out[8*g +: 8]));
  end

  always_comb begin
    t = w_prev;
    if (pos == 3'd0)
      t = sb_out ^ {rcon, 24'h000000};
    else if (NK == 8 && pos == 3'd4)
      t = sb_out;
    w_new = w_back ^ t;
  end

  // Effective round and first word index of the requested round key.
  assign eff_round = bus.decrypt_in ? (NB'(NR) - bus.round_number_in) : bus.round_number_in;
  assign kb        = IW'({eff_round, 2'b00});

  // Controller and registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= IDLE;
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      rk_r    <= '0;
      idx     <= '0;
      pos     <= '0;
      rcon    <= 8'h01;
    end else begin
      valid_r <= 1'b0;
      err_r   <= 1'b0;
`ifdef AES_KEYEXP_ZEROIZE_EN
      if (zeroize_in) begin
        state   <= IDLE;
        busy_r  <= 1'b0;
        ready_r <= 1'b0;
        rk_r    <= '0;
        idx     <= '0;
        pos     <= '0;
        rcon    <= 8'h01;
      end else
`endif
      if (bus.key_load_in) begin
        // Load wins over a same-cycle request and restarts any expansion.
        state   <= EXPAND;
        busy_r  <= 1'b1;
        ready_r <= 1'b0;
        idx     <= IW'(NK);
        pos     <= '0;
        rcon    <= 8'h01;
      end else begin
        case (state)
          EXPAND: begin
            idx <= idx + IW'(1);
            pos <= (pos == 3'(NK - 1)) ? 3'd0 : pos + 3'd1;
            if (pos == 3'd0)
              rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            if (idx == IW'(TW - 1)) begin
              state   <= READY;
              busy_r  <= 1'b0;
              ready_r <= 1'b1;
            end
          end
          READY: begin
            if (bus.round_key_req_in) begin
              if (bus.round_number_in > NB'(NR)) begin
                err_r <= 1'b1;
              end else begin
                rk_r    <= {w[kb], w[kb + IW'(1)], w[kb + IW'(2)], w[kb + IW'(3)]};
                valid_r <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Word store: no reset, contents only meaningful after a completed load.
  always_ff @(posedge clk_in) begin
`ifdef AES_KEYEXP_ZEROIZE_EN
    if (zeroize_in) begin
      for (int k = 0; k < TW; k++) w[k] <= '0;
    end else
`endif
    if (bus.key_load_in) begin
      for (int k = 0; k < NK; k++) w[k] <= bus.cipher_key_in[(NK - 1 - k) * 32 +: 32];
    end else if (state == EXPAND) begin
      w[idx] <= w_new;
    end
  end
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander
//   Directed and randomized checks of aes_key_expander (AES-256 defaults)
//   against a FIPS-197 style key-schedule model built from a brute-force
//   S-box and an Rcon table.
module tb_aes_key_expander;
  localparam int NK = 8;
  localparam int NR = 14;
  localparam int NB = 4;
  localparam int TW = 60;
  localparam int L  = TW - NK;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef AES_KEYEXP_ZEROIZE_EN
  logic zeroize;
`endif
  logic [1:0] fsm_state;

  aes_key_expander_if #(.NK__KEY_LENGTH(NK), .NB__BLOCK_LENGTH_IN_TEXT(NB)) bus();

  aes_key_expander #(
    .NK__KEY_LENGTH(NK), .NR__ROUNDS(NR), .NB__BLOCK_LENGTH_IN_TEXT(NB)
  ) dut (
    .clk_in     (clk),
    .rst_in     (rst),
`ifdef AES_KEYEXP_ZEROIZE_EN
    .zeroize_in (zeroize),
`endif
    .bus        (bus),
    .fsm_state  (fsm_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0]   sbox_t [256];
  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [31:0]  exp_w [TW];
  logic [127:0] exp_hold;
  logic [127:0] exp_q [$];
  logic [255:0] key_a;
  logic [255:0] key_b;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
               ^ inv[(i + 7) % 8] ^ c[i];
      sbox_t[a] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  task automatic build_model(input logic [255:0] k);
    logic [31:0] t;
    for (int i = 0; i < NK; i++) exp_w[i] = k[255 - 32 * i -: 32];
    for (int i = NK; i < TW; i++) begin
      t = exp_w[i - 1];
      if (i % NK == 0)
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i / NK - 1], 24'h000000};
      else if (NK > 6 && i % NK == 4)
        t = sub_word(t);
      exp_w[i] = exp_w[i - NK] ^ t;
    end
  endtask

  function automatic logic [127:0] model_key(input int r, input bit dec);
    int e;
    e = dec ? NR - r : r;
    return {exp_w[4 * e], exp_w[4 * e + 1], exp_w[4 * e + 2], exp_w[4 * e + 3]};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks (all entered and left 1ns after a rising edge)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [255:0] k, input string tag);
    bus.cipher_key_in = k;
    bus.key_load_in   = 1'b1;
    tick();
    bus.key_load_in   = 1'b0;
    build_model(k);
    check({tag, "_busy"},  128'(bus.busy_out), 128'(1));
    check({tag, "_ready"}, 128'(bus.ready_out), 128'(0));
  endtask

  task automatic wait_ready(input int already, input string tag);
    int n;
    n = already;
    while (bus.ready_out !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(L));
    check({tag, "_busy_low"}, 128'(bus.busy_out), 128'(0));
  endtask

  task automatic request(input int r, input bit dec, input string tag);
    logic [127:0] exp;
    bus.round_key_req_in = 1'b1;
    bus.round_number_in  = 4'(r);
    bus.decrypt_in       = dec;
    tick();
    bus.round_key_req_in = 1'b0;
    if (r > NR) begin
      check({tag, "_err"},   128'(bus.range_err_out), 128'(1));
      check({tag, "_valid"}, 128'(bus.round_key_valid_out), 128'(0));
      check({tag, "_hold"},  bus.round_key_out, exp_hold);
    end else begin
      exp_q.push_back(model_key(r, dec));
      exp = exp_q.pop_front();
      exp_hold = exp;
      check({tag, "_valid"}, 128'(bus.round_key_valid_out), 128'(1));
      check({tag, "_err"},   128'(bus.range_err_out), 128'(0));
      check({tag, "_key"},   bus.round_key_out, exp);
    end
  endtask

  initial begin
    logic seen;
    build_sbox();
    exp_hold = '0;
    key_a = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    // Reset
    rst = 1'b1;
`ifdef AES_KEYEXP_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    bus.key_load_in = 1'b0;
    bus.cipher_key_in = '0;
    bus.round_key_req_in = 1'b0;
    bus.round_number_in = '0;
    bus.decrypt_in = 1'b0;
    #1;
    check("rst_busy",  128'(bus.busy_out), 128'(0));
    check("rst_ready", 128'(bus.ready_out), 128'(0));
    check("rst_valid", 128'(bus.round_key_valid_out), 128'(0));
    check("rst_err",   128'(bus.range_err_out), 128'(0));
    check("rst_key",   bus.round_key_out, 128'(0));
    tick();
    tick();
    rst = 1'b0;

    // Known-answer key with an early request during expansion
    load_key(key_a, "kat_load");
    for (int i = 0; i < 9; i++) tick();
    bus.round_key_req_in = 1'b1;
    bus.round_number_in  = 4'd1;
    bus.decrypt_in       = 1'b0;
    tick();
    bus.round_key_req_in = 1'b0;
    check("early_valid", 128'(bus.round_key_valid_out), 128'(0));
    check("early_err",   128'(bus.range_err_out), 128'(0));
    check("early_busy",  128'(bus.busy_out), 128'(1));
    check("early_key",   bus.round_key_out, exp_hold);
    wait_ready(10, "kat");

    request(1, 1'b0, "kat_r1");
    check("kat_r1_const", bus.round_key_out, 128'h101112131415161718191a1b1c1d1e1f);
    request(2, 1'b0, "kat_r2");
    check("kat_r2_const", bus.round_key_out, 128'ha573c29fa176c498a97fce93a572c09c);
    request(0, 1'b1, "kat_d0");
    check("kat_d0_const", bus.round_key_out, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    request(14, 1'b1, "kat_d14");
    check("kat_d14_const", bus.round_key_out, 128'h000102030405060708090a0b0c0d0e0f);
    request(15, 1'b0, "kat_r15");
    tick();
    check("pulse_clear", 128'(bus.round_key_valid_out), 128'(0));

    // Load in the same cycle as a request: load wins, no response
    for (int j = 0; j < 8; j++) key_b[32 * j +: 32] = $urandom();
    bus.round_key_req_in = 1'b1;
    bus.round_number_in  = 4'd3;
    bus.cipher_key_in    = key_b;
    bus.key_load_in      = 1'b1;
    tick();
    bus.key_load_in      = 1'b0;
    bus.round_key_req_in = 1'b0;
    build_model(key_b);
    check("ldreq_valid", 128'(bus.round_key_valid_out), 128'(0));
    check("ldreq_busy",  128'(bus.busy_out), 128'(1));
    check("ldreq_ready", 128'(bus.ready_out), 128'(0));
    check("ldreq_hold",  bus.round_key_out, exp_hold);
    wait_ready(0, "ldreq");
    request(5, 1'b0, "ldreq_r5");

    // Reload mid-expansion
    for (int j = 0; j < 8; j++) key_a[32 * j +: 32] = $urandom();
    for (int j = 0; j < 8; j++) key_b[32 * j +: 32] = $urandom();
    load_key(key_a, "reload_a");
    for (int i = 0; i < 19; i++) tick();
    load_key(key_b, "reload_b");
    wait_ready(0, "reload");
    request(1, 1'b0, "reload_r1");
    check("reload_r1_words", bus.round_key_out, key_b[127:0]);

    // Randomized keys and back-to-back random requests
    for (int kk = 0; kk < 4; kk++) begin
      for (int j = 0; j < 8; j++) key_a[32 * j +: 32] = $urandom();
      load_key(key_a, "rnd_load");
      wait_ready(0, "rnd");
      for (int q = 0; q < 10; q++)
        request($urandom_range(0, 15), 1'($urandom_range(0, 1)), "rnd_req");
    end

    // Reset mid-expansion
    load_key(key_a, "rst_load");
    for (int i = 0; i < 10; i++) tick();
    #3;
    rst = 1'b1;
    #1;
    exp_hold = '0;
    check("arst_busy",  128'(bus.busy_out), 128'(0));
    check("arst_ready", 128'(bus.ready_out), 128'(0));
    check("arst_valid", 128'(bus.round_key_valid_out), 128'(0));
    check("arst_err",   128'(bus.range_err_out), 128'(0));
    check("arst_key",   bus.round_key_out, 128'(0));
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick();
      seen = seen | bus.ready_out;
    end
    check("arst_ready_stays_low", 128'(seen), 128'(0));
    for (int j = 0; j < 8; j++) key_a[32 * j +: 32] = $urandom();
    load_key(key_a, "post_rst_load");
    wait_ready(0, "post_rst");
    request(7, 1'b1, "post_rst_d7");
    request(0, 1'b0, "post_rst_r0");

`ifdef AES_KEYEXP_ZEROIZE_EN
    // Zeroize in READY
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    exp_hold = '0;
    check("zero_ready", 128'(bus.ready_out), 128'(0));
    check("zero_key",   bus.round_key_out, 128'(0));
    bus.round_key_req_in = 1'b1;
    bus.round_number_in  = 4'd2;
    tick();
    bus.round_key_req_in = 1'b0;
    check("zero_req_valid", 128'(bus.round_key_valid_out), 128'(0));
    check("zero_req_key",   bus.round_key_out, 128'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
